// File: rtl/jtframe_mr_ddrld_pkg.sv
// Shared definitions for the DDR fast ROM loader: FSM states and DDR word geometry.
package jtframe_mr_ddrld_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StFill,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned DDR_WBYTES = 8;
  localparam int unsigned ByteSelW   = $clog2(DDR_WBYTES);
  localparam int unsigned BcntW      = 8;

endpackage

// File: rtl/jtframe_mr_ddrld_buf.sv
// Burst buffer: simple dual-port RAM, one write port, registered read port.
module jtframe_mr_ddrld_buf #(
  parameter int unsigned Depth = 32,
  parameter int unsigned Aw    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [Aw-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [Aw-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/jtframe_mr_ddrld.sv
// Fast ROM loader: reads the ROM image from DDR in bursts, buffers each burst and
// serialises it into the byte-wide prog_* download stream.
module jtframe_mr_ddrld
  import jtframe_mr_ddrld_pkg::*;
#(
  parameter logic [28:0] DDR_BASE = 29'h0600_0000,
  parameter int unsigned BURST    = 32,
  parameter int unsigned AW       = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     rom_len,
  input  logic              ddr_busy,
  input  logic              ddr_dout_ready,
  input  logic [63:0]       ddr_dout,
  output logic [BcntW-1:0]  ddr_burstcnt,
  output logic [28:0]       ddr_addr,
  output logic              ddr_rd,
  output logic [AW-1:0]     prog_addr,
  output logic [7:0]        prog_data,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              downloading,
  output logic              done
);

  localparam int unsigned BufAw = (BURST > 1) ? $clog2(BURST) : 1;

  state_e                state;
  logic [AW-1:0]         bytes_left;
  logic [28:0]           widx;
  logic [BcntW-1:0]      wptr, rptr, rptr_nxt;
  logic [ByteSelW-1:0]   bsel;
  logic [63:0]           buf_rdata;
  logic [BufAw-1:0]      buf_raddr;
  logic                  buf_we, byte_acc, last_byte, last_in_word, last_in_burst;

  // min(BURST, ceil(nbytes/8))
  function automatic logic [BcntW-1:0] burst_len(input logic [AW-1:0] nbytes);
    logic [AW:0] words;
    words = ({1'b0, nbytes} + (AW+1)'(DDR_WBYTES - 1)) >> ByteSelW;
    if (words > (AW+1)'(BURST)) return BcntW'(BURST);
    return words[BcntW-1:0];
  endfunction

  assign byte_acc      = (state == StDrain) && prog_we && prog_rdy;
  assign last_in_word  = bsel == ByteSelW'(DDR_WBYTES - 1);
  assign rptr_nxt      = rptr + 1'b1;
  assign last_in_burst = last_in_word && (rptr_nxt == ddr_burstcnt);
  assign last_byte     = bytes_left == AW'(1);
  assign buf_we        = (state == StFill) && ddr_dout_ready && (wptr < ddr_burstcnt);
  // Prefetch the next word on the accepting edge so it is ready for the next byte.
  assign buf_raddr     = (byte_acc && last_in_word) ? rptr_nxt[BufAw-1:0] : rptr[BufAw-1:0];

  jtframe_mr_ddrld_buf #(
    .Depth (BURST),
    .Aw    (BufAw)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wptr[BufAw-1:0]),
    .wdata (ddr_dout),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      bytes_left   <= '0;
      widx         <= '0;
      wptr         <= '0;
      rptr         <= '0;
      bsel         <= '0;
      ddr_rd       <= 1'b0;
      ddr_addr     <= '0;
      ddr_burstcnt <= '0;
      prog_addr    <= '0;
      prog_data    <= '0;
      prog_we      <= 1'b0;
      downloading  <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (rom_len != '0) begin
              bytes_left   <= rom_len;
              widx         <= DDR_BASE;
              prog_addr    <= '0;
              downloading  <= 1'b1;
              ddr_rd       <= 1'b1;
              ddr_addr     <= DDR_BASE;
              ddr_burstcnt <= burst_len(rom_len);
              state        <= StReq;
            end else begin
              done  <= 1'b1;
              state <= StDone;
            end
          end
        end
        StReq: begin
          if (!ddr_busy) begin
            ddr_rd <= 1'b0;
            wptr   <= '0;
            rptr   <= '0;
            bsel   <= '0;
            state  <= StFill;
          end
        end
        StFill: begin
          if (buf_we) wptr <= wptr + 1'b1;
          if (wptr == ddr_burstcnt) begin
            widx  <= widx + 29'(ddr_burstcnt);
            state <= StDrain;
          end
        end
        StDrain: begin
          if (!prog_we) begin
            prog_we   <= 1'b1;
            prog_data <= buf_rdata[{bsel, 3'b000} +: 8];
          end else if (prog_rdy) begin
            prog_we    <= 1'b0;
            bytes_left <= bytes_left - AW'(1);
            if (last_byte) begin
              // Pad bytes of the final word are simply never presented.
              done        <= 1'b1;
              downloading <= 1'b0;
              state       <= StDone;
            end else begin
              prog_addr <= prog_addr + 1'b1;
              bsel      <= bsel + 1'b1;
              if (last_in_word) rptr <= rptr_nxt;
              if (last_in_burst) begin
                ddr_rd       <= 1'b1;
                ddr_addr     <= widx;
                ddr_burstcnt <= burst_len(bytes_left - AW'(1));
                state        <= StReq;
              end
            end
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_mr_ddrld.sv
// Scoreboard bench for jtframe_mr_ddrld: a DDR responder model and a prog_* sink.
module tb_jtframe_mr_ddrld;

  localparam logic [28:0] DdrBase = 29'h0600_0000;
  localparam int Burst = 32;
  localparam int Aw = 27;
  localparam int HoldCycles = 10;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [Aw-1:0] rom_len;
  logic          ddr_busy, ddr_dout_ready;
  logic [63:0]   ddr_dout;
  logic [7:0]    ddr_burstcnt;
  logic [28:0]   ddr_addr;
  logic          ddr_rd;
  logic [Aw-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          prog_we, prog_rdy, downloading, done;

  always #5 clk = ~clk;

  jtframe_mr_ddrld #(
    .DDR_BASE (DdrBase),
    .BURST    (Burst),
    .AW       (Aw)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .rom_len        (rom_len),
    .ddr_busy       (ddr_busy),
    .ddr_dout_ready (ddr_dout_ready),
    .ddr_dout       (ddr_dout),
    .ddr_burstcnt   (ddr_burstcnt),
    .ddr_addr       (ddr_addr),
    .ddr_rd         (ddr_rd),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .prog_we        (prog_we),
    .prog_rdy       (prog_rdy),
    .downloading    (downloading),
    .done           (done)
  );

  typedef struct { logic [28:0] addr; logic [7:0] bc; } req_t;
  typedef struct { logic [Aw-1:0] addr; logic [7:0] data; } byte_t;

  req_t  exp_req[$];
  byte_t exp_byte[$];

  int n_vec = 0, n_err = 0;
  int busy_arm = 0;
  int hold_addr = -1, hold_left = 0;
  int words_sent = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] img_byte(input longint b);
    return 8'(b * 7 + 3) ^ 8'(b >> 8);
  endfunction

  function automatic logic [63:0] img_word(input logic [28:0] a);
    logic [63:0] w;
    longint base;
    base = longint'(a - DdrBase) * 8;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = img_byte(base + k);
    return w;
  endfunction

  // Expected requests and bytes for one image load.
  task automatic plan(input int len);
    int bl;
    logic [28:0] a;
    bl = len;
    a = DdrBase;
    for (int i = 0; i < len; i++) exp_byte.push_back('{addr: Aw'(i), data: img_byte(i)});
    while (bl > 0) begin
      int w, bc;
      w = (bl + 7) / 8;
      bc = (w > Burst) ? Burst : w;
      exp_req.push_back('{addr: a, bc: 8'(bc)});
      a = a + 29'(bc);
      bl = (bc * 8 > bl) ? 0 : bl - bc * 8;
    end
  endtask

  // DDR responder: stale words keep streaming across reset, a new acceptance replaces them.
  initial begin
    int words_left, delay;
    bit req_seen, extra;
    int busy_left;
    logic [28:0] cur_addr, ref_addr;
    logic [7:0] ref_bc;
    req_t r;
    words_left = 0; delay = 0; req_seen = 0; extra = 0; busy_left = 0;
    ddr_busy = 1'b0; ddr_dout_ready = 1'b0; ddr_dout = '0;
    forever begin
      @(negedge clk);
      ddr_dout_ready = 1'b0;
      if (words_left > 0) begin
        if (delay > 0) delay--;
        else begin
          ddr_dout_ready = 1'b1;
          ddr_dout = img_word(cur_addr);
          cur_addr++;
          words_left--;
          words_sent++;
          delay = $urandom_range(0, 1);
        end
      end else if (extra) begin
        ddr_dout_ready = 1'b1;
        ddr_dout = 64'hDEAD_BEEF_0BAD_F00D;
        extra = 0;
      end
      if (ddr_rd && !rst) begin
        if (!req_seen) begin
          req_seen = 1; ref_addr = ddr_addr; ref_bc = ddr_burstcnt;
          busy_left = busy_arm; busy_arm = 0;
        end else begin
          check("req_stable_addr", ddr_addr, ref_addr);
          check("req_stable_bc", ddr_burstcnt, ref_bc);
        end
        if (busy_left > 0) begin
          ddr_busy = 1'b1;
          busy_left--;
        end else begin
          ddr_busy = 1'b0;
          req_seen = 0;
          check("req_pending", 64'(exp_req.size() != 0), 1);
          if (exp_req.size() != 0) begin
            r = exp_req.pop_front();
            check("ddr_addr", ddr_addr, r.addr);
            check("ddr_burstcnt", ddr_burstcnt, r.bc);
          end
          words_left = ddr_burstcnt; cur_addr = ddr_addr; delay = 2; extra = 1;
        end
      end else begin
        ddr_busy = 1'b0;
        req_seen = 0;
      end
    end
  end

  // prog_* sink: random back-pressure, optional long hold on one address.
  initial begin
    logic [7:0] hold_data;
    byte_t e;
    hold_data = '0;
    prog_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !prog_we) begin
        prog_rdy = ($urandom_range(0, 1) == 1);
      end else if (hold_left > 0 && int'(prog_addr) == hold_addr) begin
        prog_rdy = 1'b0;
        if (hold_left == HoldCycles) hold_data = prog_data;
        else begin
          check("hold_data", prog_data, hold_data);
          check("hold_addr", prog_addr, 64'(hold_addr));
        end
        hold_left--;
      end else begin
        prog_rdy = ($urandom_range(0, 3) != 0);
        if (prog_rdy) begin
          check("byte_pending", 64'(exp_byte.size() != 0), 1);
          if (exp_byte.size() != 0) begin
            e = exp_byte.pop_front();
            check("prog_addr", prog_addr, e.addr);
            check("prog_data", prog_data, e.data);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_ddr_rd", ddr_rd, 0);
    check("rst_ddr_addr", ddr_addr, 0);
    check("rst_ddr_bc", ddr_burstcnt, 0);
    check("rst_prog_we", prog_we, 0);
    check("rst_prog_addr", prog_addr, 0);
    check("rst_prog_data", prog_data, 0);
    check("rst_downloading", downloading, 0);
    check("rst_done", done, 0);
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic run_load(input int len, input int poke_at);
    int cyc;
    plan(len);
    rom_len = Aw'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      check("zero_done", done, 1);
      check("zero_dl", downloading, 0);
      @(negedge clk);
      check("zero_done_pulse", done, 0);
      check("zero_dl2", downloading, 0);
    end else begin
      check("dl_rise", downloading, 1);
      cyc = 0;
      while (!done && cyc < 20000) begin
        if (cyc == poke_at) begin start = 1'b1; rom_len = Aw'(5); end
        @(negedge clk);
        start = 1'b0;
        cyc++;
      end
      check("done_seen", done, 1);
      if (done) begin
        check("final_addr", prog_addr, 64'(len - 1));
        check("dl_fall", downloading, 0);
        check("we_at_done", prog_we, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
      end
    end
    check("req_q_drained", 64'(exp_req.size()), 0);
    check("byte_q_drained", 64'(exp_byte.size()), 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; rom_len = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    run_load(16, -1);
    run_load(300, 100);   // includes an ignored start mid-load
    run_load(256, -1);
    busy_arm = 5;
    run_load(20, -1);
    hold_addr = 3; hold_left = HoldCycles;
    run_load(40, -1);
    run_load(0, -1);
    run_load(9, -1);

    // Reset in the middle of the first burst fill, then reload.
    plan(300);
    words_sent = 0;
    rom_len = Aw'(300);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (words_sent < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("fill_reached", 64'(words_sent >= 3), 1);
    rst = 1'b1;
    exp_req.delete();
    exp_byte.delete();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    run_load(16, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
